fwft_packet_arbiter: RTL and testbench

Round-robin packet arbiter that merges the read sides of NUM_INPUTS first-word-fall-through FIFOs into one 36-bit output stream with a valid/ready handshake. It is built for the data concentrator: one FWFT buffer per upstream link sits in front of this block, and the downstream packet builder sits behind it. Whole packets are moved without interleaving, with an end-of-packet flag in the data word delimiting each packet. A word-count watchdog forces release of a grant whose packet never terminates.

---
 rtl/fwft_packet_arbiter.sv | 124 ++++++++++++
 tb/tb_fwft_packet_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_packet_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS FWFT FIFO read ports into one
// valid/ready stream. Packets are moved whole (EOP flag in the data word),
// and a word-count watchdog forces release of a packet that never ends.
module fwft_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 36,
    parameter int EOP_BIT    = 32,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_empty,
    output logic [NUM_INPUTS-1:0]            in_rd_en,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [3:0]                       out_src,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic {IDLE, TRANSFER} state_t;

    state_t                               state;
    logic [PW-1:0]                        ptr;
    logic [PW-1:0]                        g;
    logic [CW-1:0]                        wcnt;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] lane_data;
    logic [PW-1:0]                        nxt;
    logic                                 any_req;
    logic                                 slot_free;
    logic                                 pop;
    logic [DATA_WIDTH-1:0]                cur;
    logic                                 is_eop;
    logic                                 wd_hit;

    // Split the flat input bus into per-lane words.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        assign lane_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin scan from ptr+1; walking far-to-near lets the nearest
    // non-empty input win.
    always_comb begin
        int idx;
        idx     = 0;
        nxt     = ptr;
        any_req = 1'b0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_INPUTS;
            if (!in_empty[idx]) begin
                nxt     = PW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // Pop the granted lane whenever the output slot is free; reset blocks
    // the pop so no word is lost in the reset cycle.
    always_comb begin
        slot_free = !out_valid || out_ready;
        pop       = (state == TRANSFER) && !in_empty[g] && slot_free && !rst;
        in_rd_en  = pop ? (NUM_INPUTS'(1) << g) : '0;
        cur       = lane_data[g];
        is_eop    = cur[EOP_BIT];
        wd_hit    = (wcnt == CW'(MAX_WORDS - 1));
    end

    // Grant FSM, word counter, watchdog and registered output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= PW'(NUM_INPUTS - 1);
            g           <= '0;
            wcnt        <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_src     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            if (pop) begin
                out_data <= cur;
                // Watchdog release: mark the cut word as a packet end.
                if (wd_hit && !is_eop)
                    out_data[EOP_BIT] <= 1'b1;
                out_src   <= 4'(g);
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        g     <= nxt;
                        wcnt  <= '0;
                        busy  <= 1'b1;
                        state <= TRANSFER;
                    end
                end
                TRANSFER: begin
                    if (pop) begin
                        wcnt <= wcnt + 1'b1;
                        if (is_eop || wd_hit) begin
                            ptr         <= g;
                            busy        <= 1'b0;
                            timeout_err <= !is_eop;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fwft_packet_arbiter.sv
// Directed bench for fwft_packet_arbiter: four FWFT FIFO models feed the
// DUT, accepted output words are logged, and each step is checked against
// hand-computed values.
module tb_fwft_packet_arbiter;

    localparam int N  = 4;
    localparam int W  = 36;
    localparam int MW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_empty;
    logic [N-1:0]     in_rd_en;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       out_src;
    logic             busy;
    logic             timeout_err;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int base = 0;

    logic [W-1:0] mem [N][32];
    int           rp [N] = '{default: 0};
    int           wp [N] = '{default: 0};

    logic [39:0]  acc_word [$];
    int           acc_cyc  [$];

    fwft_packet_arbiter #(
        .NUM_INPUTS(N), .DATA_WIDTH(W), .EOP_BIT(32), .MAX_WORDS(MW)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // FWFT FIFO models: head word always visible, pop on rd_en.
    for (genvar i = 0; i < N; i++) begin : g_fifo
        assign in_data[i*W +: W] = mem[i][rp[i] % 32];
        assign in_empty[i]       = (rp[i] == wp[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (in_rd_en[i]) rp[i] <= rp[i] + 1;
    end

    // Log every word the sink accepts, with its cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            acc_word.push_back({out_src, out_data});
            acc_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [W-1:0] d);
        mem[i][wp[i] % 32] = d;
        wp[i] = wp[i] + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input int k, input logic [39:0] exp);
        logic [63:0] v;
        v = (base + k < acc_word.size()) ? 64'(acc_word[base + k]) : '1;
        chk(tag, v, 64'(exp));
    endtask

    task automatic wait_acc(input string tag, input int n);
        int c;
        c = 0;
        while (acc_word.size() < base + n && c < 60) begin
            step();
            c++;
        end
        repeat (3) step();
        chk(tag, 64'(acc_word.size() - base), 64'(n));
    endtask

    initial begin
        logic [39:0] e;

        // ---- reset values
        rst = 1'b1;
        repeat (2) step();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_rden",  64'(in_rd_en), 64'(0));
        chk("rst_data",  64'(out_data), 64'(0));
        chk("rst_src",   64'(out_src), 64'(0));
        chk("rst_tmo",   64'(timeout_err), 64'(0));
        rst = 1'b0;
        step();

        // ---- single input: latency and streaming
        push(2, 36'h0_0000_0001);
        push(2, 36'h0_0000_0002);
        push(2, 36'h1_0000_0003);
        step();
        chk("single_busy", 64'(busy), 64'(1));
        chk("single_rden", 64'(in_rd_en), 64'(4'b0100));
        chk("single_nov",  64'(out_valid), 64'(0));
        step();
        chk("single_w1", 64'({out_valid, out_src, out_data}), 64'({1'b1, 4'd2, 36'h0_0000_0001}));
        step();
        chk("single_w2", 64'({out_valid, out_src, out_data}), 64'({1'b1, 4'd2, 36'h0_0000_0002}));
        step();
        chk("single_w3", 64'({out_valid, out_src, out_data}), 64'({1'b1, 4'd2, 36'h1_0000_0003}));
        chk("single_idle", 64'(busy), 64'(0));
        step();
        chk("single_drain", 64'(out_valid), 64'(0));

        // ---- round robin from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        base = acc_word.size();
        for (int i = 0; i < N; i++) begin
            push(i, 36'(i * 16 + 1));
            push(i, 36'h1_0000_0000 | 36'(i * 16 + 2));
        end
        wait_acc("rr_count", 8);
        for (int k = 0; k < 8; k++) begin
            e = {4'(k / 2), ((k % 2) ? 36'h1_0000_0000 : 36'h0) | 36'((k / 2) * 16 + (k % 2) + 1)};
            chk_acc("rr_word", k, e);
        end
        for (int k = 1; k < 8; k++)
            chk("rr_gap", 64'(acc_cyc[base + k] - acc_cyc[base + k - 1]), 64'((k % 2) ? 1 : 2));

        // ---- fairness: input 0 always has more, input 3 has one packet
        base = acc_word.size();
        push(0, 36'h0_0000_00A1);
        push(0, 36'h1_0000_00A2);
        push(3, 36'h0_0000_00D1);
        push(3, 36'h1_0000_00D2);
        push(0, 36'h0_0000_00B1);
        push(0, 36'h1_0000_00B2);
        wait_acc("fair_count", 6);
        chk_acc("fair_0", 0, {4'd0, 36'h0_0000_00A1});
        chk_acc("fair_1", 1, {4'd0, 36'h1_0000_00A2});
        chk_acc("fair_2", 2, {4'd3, 36'h0_0000_00D1});
        chk_acc("fair_3", 3, {4'd3, 36'h1_0000_00D2});
        chk_acc("fair_4", 4, {4'd0, 36'h0_0000_00B1});
        chk_acc("fair_5", 5, {4'd0, 36'h1_0000_00B2});

        // ---- backpressure on a 5-word packet (wcnt hits MAX_WORDS on EOP)
        base = acc_word.size();
        for (int k = 1; k <= 5; k++)
            push(1, ((k == 5) ? 36'h1_0000_0000 : 36'h0) | 36'(8'h70 + k));
        step();
        chk("bp_rden1", 64'(in_rd_en), 64'(4'b0010));
        step();
        chk("bp_w1", 64'({out_valid, out_data}), 64'({1'b1, 36'h0_0000_0071}));
        out_ready = 1'b0;
        #1;
        chk("bp_stall_rden_a", 64'(in_rd_en), 64'(0));
        step();
        chk("bp_hold", 64'({out_valid, out_src, out_data}), 64'({1'b1, 4'd1, 36'h0_0000_0071}));
        chk("bp_stall_rden_b", 64'(in_rd_en), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_resume_rden", 64'(in_rd_en), 64'(4'b0010));
        repeat (4) step();
        chk("bp_w5", 64'(out_data), 64'(36'h1_0000_0075));
        chk("bp_no_tmo", 64'(timeout_err), 64'(0));
        chk("bp_idle", 64'(busy), 64'(0));
        wait_acc("bp_count", 5);
        for (int k = 0; k < 5; k++)
            chk_acc("bp_word", k, {4'd1, ((k == 4) ? 36'h1_0000_0000 : 36'h0) | 36'(8'h71 + k)});

        // ---- watchdog: 7 words without EOP, cut after word 5
        base = acc_word.size();
        for (int k = 1; k <= 7; k++)
            push(1, 36'(8'h50 + k));
        step();
        repeat (5) step();
        chk("wd_forced", 64'(out_data), 64'(36'h1_0000_0055));
        chk("wd_tmo_hi", 64'(timeout_err), 64'(1));
        chk("wd_release", 64'(busy), 64'(0));
        step();
        chk("wd_tmo_lo", 64'(timeout_err), 64'(0));
        repeat (4) step();
        chk("wd_hold_busy", 64'(busy), 64'(1));
        chk("wd_hold_rden", 64'(in_rd_en), 64'(0));
        push(1, 36'h1_0000_0058);
        wait_acc("wd_count", 8);
        for (int k = 0; k < 8; k++)
            chk_acc("wd_word", k, {4'd1, ((k == 4 || k == 7) ? 36'h1_0000_0000 : 36'h0) | 36'(8'h51 + k)});
        chk("wd_tmo_end", 64'(timeout_err), 64'(0));

        // ---- reset during word 2 of a 4-word packet
        base = acc_word.size();
        push(2, 36'h0_0000_0061);
        push(2, 36'h0_0000_0062);
        push(2, 36'h0_0000_0063);
        push(2, 36'h1_0000_0064);
        repeat (3) step();
        chk("rm_w2", 64'(out_data), 64'(36'h0_0000_0062));
        rst = 1'b1;
        #1;
        chk("rm_no_pop", 64'(in_rd_en), 64'(0));
        step();
        chk("rm_outs", 64'({out_valid, busy, timeout_err, out_src, out_data}), 64'(0));
        chk("rm_fifo_left", 64'(wp[2] - rp[2]), 64'(2));
        rst = 1'b0;
        wait_acc("rm_count", 3);
        chk_acc("rm_0", 0, {4'd2, 36'h0_0000_0061});
        chk_acc("rm_1", 1, {4'd2, 36'h0_0000_0063});
        chk_acc("rm_2", 2, {4'd2, 36'h1_0000_0064});

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
